// File: rtl/risp_neuron_ext.sv
// -----------------------------------------------------------------------------
// risp_neuron_ext
//
// Single integrate-and-fire neuron for the generated spiking network. Each
// step (i_en high) it leaks the stored potential, adds the input charges and
// compares the sum against a runtime-loadable threshold. On a fire the
// potential returns to zero, a saturating fire counter advances and, when
// REFRACTORY > 0, the neuron ignores its inputs for REFRACTORY further steps.
//
// Parameters
//   NUM_INP             number of input charges
//   CHARGE_WIDTH        signed width of each input charge
//   POTENTIAL_WIDTH     signed width of the stored potential
//   THRESHOLD           threshold value loaded at reset
//   POTENTIAL_MIN       lower clamp on the stored potential (<= 0)
//   THRESHOLD_INCLUSIVE 1: fire on sum >= thr, 0: fire on sum > thr
//   LEAK_MODE           0: none, 1: full leak, 2: shift decay
//   LEAK_SHIFT          decay shift for LEAK_MODE 2 (>= 1)
//   REFRACTORY          dead steps after a fire, 0 disables
//   REGISTER_FIRE       1: o_fire is registered, 0: o_fire is combinational
//   COUNT_WIDTH         width of the saturating fire counter
//
// Ports
//   i_clk         clock, all state changes on the rising edge
//   i_rst         synchronous active-high reset of everything
//   i_clr         synchronous clear of everything except the threshold
//   i_en          step strobe, state advances only when high
//   i_inp         input charges, element k is i_inp[k] (signed)
//   i_thr_load    load i_thr_value into the threshold register
//   i_thr_value   new threshold (signed)
//   o_fire        spike for the current step
//   o_potential   stored potential (signed)
//   o_refractory  high while in the refractory state
//   o_fire_count  fires since the last reset/clear, saturating
// -----------------------------------------------------------------------------
module risp_neuron_ext #(
    parameter int NUM_INP             = 1,
    parameter int CHARGE_WIDTH        = 8,
    parameter int POTENTIAL_WIDTH     = 12,
    parameter logic signed [POTENTIAL_WIDTH-1:0] THRESHOLD = '0,
    parameter int POTENTIAL_MIN       = 0,
    parameter int THRESHOLD_INCLUSIVE = 1,
    parameter int LEAK_MODE           = 0,
    parameter int LEAK_SHIFT          = 1,
    parameter int REFRACTORY          = 0,
    parameter int REGISTER_FIRE       = 0,
    parameter int COUNT_WIDTH         = 16
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    i_clr,
    input  logic                                    i_en,
    input  logic [NUM_INP-1:0][CHARGE_WIDTH-1:0]    i_inp,
    input  logic                                    i_thr_load,
    input  logic signed [POTENTIAL_WIDTH-1:0]       i_thr_value,
    output logic                                    o_fire,
    output logic signed [POTENTIAL_WIDTH-1:0]       o_potential,
    output logic                                    o_refractory,
    output logic [COUNT_WIDTH-1:0]                  o_fire_count
);

    // Wide enough that the leak base plus every charge can never wrap.
    localparam int MAX_W     = (POTENTIAL_WIDTH > CHARGE_WIDTH) ? POTENTIAL_WIDTH : CHARGE_WIDTH;
    localparam int SUM_WIDTH = MAX_W + $clog2(NUM_INP + 1) + 1;

    // With REFRACTORY == 0 the counter is kept as a constant-zero bit so the
    // code below needs no special casing; it never leaves zero.
    localparam int RC_WIDTH  = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

    localparam logic signed [POTENTIAL_WIDTH-1:0] POT_MAX = {1'b0, {(POTENTIAL_WIDTH-1){1'b1}}};
    localparam logic signed [POTENTIAL_WIDTH-1:0] POT_MIN = POTENTIAL_WIDTH'(POTENTIAL_MIN);
    localparam logic signed [SUM_WIDTH-1:0]       SUM_POT_MAX = SUM_WIDTH'(POT_MAX);
    localparam logic signed [SUM_WIDTH-1:0]       SUM_POT_MIN = SUM_WIDTH'(POT_MIN);

    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_REFRACT = 1'b1
    } state_t;

    state_t                              r_state;
    state_t                              w_stateNext;
    logic [RC_WIDTH-1:0]                 r_rc;
    logic [RC_WIDTH-1:0]                 w_rcNext;
    logic signed [POTENTIAL_WIDTH-1:0]   r_potential;
    logic signed [POTENTIAL_WIDTH-1:0]   w_potentialNext;
    logic [COUNT_WIDTH-1:0]              r_fireCount;
    logic [COUNT_WIDTH-1:0]              w_fireCountNext;
    logic signed [POTENTIAL_WIDTH-1:0]   r_thr;

    logic signed [POTENTIAL_WIDTH-1:0]   w_base;
    logic signed [SUM_WIDTH-1:0]         w_sum;
    logic signed [SUM_WIDTH-1:0]         w_thrExt;
    logic                                w_overThr;
    logic signed [POTENTIAL_WIDTH-1:0]   w_potClamped;
    logic                                w_doFire;

    // Leak base. The decay form p - (p >>> s) rounds toward zero for
    // negative potentials, so -1 decays to 0 rather than sticking.
    always_comb begin
        w_base = r_potential;
        if (LEAK_MODE == 1) begin
            w_base = '0;
        end else if (LEAK_MODE == 2) begin
            w_base = r_potential - (r_potential >>> LEAK_SHIFT);
        end
    end

    // Accumulate the leak base and all charges in the widened sum domain.
    always_comb begin
        w_sum = SUM_WIDTH'(w_base);
        for (int k = 0; k < NUM_INP; k++) begin
            w_sum = w_sum + SUM_WIDTH'($signed(i_inp[k]));
        end
    end

    // Threshold compare against the value held before any load this cycle.
    assign w_thrExt  = SUM_WIDTH'(r_thr);
    assign w_overThr = (THRESHOLD_INCLUSIVE != 0) ? (w_sum >= w_thrExt) : (w_sum > w_thrExt);

    // Saturate the sum into the storable potential range.
    always_comb begin
        if (w_sum > SUM_POT_MAX) begin
            w_potClamped = POT_MAX;
        end else if (w_sum < SUM_POT_MIN) begin
            w_potClamped = POT_MIN;
        end else begin
            w_potClamped = w_sum[POTENTIAL_WIDTH-1:0];
        end
    end

    // Next-state logic. Everything holds unless i_en strobes a step. In the
    // refractory state the counter is loaded with REFRACTORY at the fire and
    // the state returns to normal on the step where it reads 1, giving
    // exactly REFRACTORY dead steps.
    always_comb begin
        w_stateNext     = r_state;
        w_rcNext        = r_rc;
        w_potentialNext = r_potential;
        w_fireCountNext = r_fireCount;
        w_doFire        = 1'b0;
        if (i_en) begin
            case (r_state)
                ST_NORMAL: begin
                    if (w_overThr) begin
                        w_doFire        = 1'b1;
                        w_potentialNext = '0;
                        if (r_fireCount != {COUNT_WIDTH{1'b1}}) begin
                            w_fireCountNext = r_fireCount + COUNT_WIDTH'(1);
                        end
                        if (REFRACTORY > 0) begin
                            w_stateNext = ST_REFRACT;
                            w_rcNext    = RC_WIDTH'(REFRACTORY);
                        end
                    end else begin
                        w_potentialNext = w_potClamped;
                    end
                end
                ST_REFRACT: begin
                    w_potentialNext = '0;
                    w_rcNext        = r_rc - RC_WIDTH'(1);
                    if (r_rc == RC_WIDTH'(1)) begin
                        w_stateNext = ST_NORMAL;
                    end
                end
                default: begin
                    w_stateNext = ST_NORMAL;
                    w_rcNext    = '0;
                end
            endcase
        end
    end

    // Neuron state registers; clear behaves like reset for these.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_state     <= ST_NORMAL;
            r_rc        <= '0;
            r_potential <= '0;
            r_fireCount <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_rc        <= w_rcNext;
            r_potential <= w_potentialNext;
            r_fireCount <= w_fireCountNext;
        end
    end

    // Threshold register survives a clear, and a load coinciding with a
    // clear still takes effect. Loads ignore i_en and the refractory state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_thr <= THRESHOLD;
        end else if (i_thr_load) begin
            r_thr <= i_thr_value;
        end
    end

    // Fire output: either the raw step decision (combinational path from
    // inputs, i_en and threshold) or that decision captured on step edges.
    generate
        if (REGISTER_FIRE != 0) begin : g_fireReg
            logic r_fire;
            always_ff @(posedge i_clk) begin
                if (i_rst || i_clr) begin
                    r_fire <= 1'b0;
                end else if (i_en) begin
                    r_fire <= w_doFire;
                end
            end
            assign o_fire = r_fire;
        end else begin : g_fireComb
            assign o_fire = w_doFire;
        end
    endgenerate

    assign o_potential  = r_potential;
    assign o_refractory = (r_state == ST_REFRACT);
    assign o_fire_count = r_fireCount;

endmodule

// File: doc/risp_neuron_ext.md
# risp_neuron_ext

Parametrised successor to the base RISP neuron: a single integrate-and-fire neuron with a runtime-loadable threshold, three leak modes (none, full, shift-decay), an optional refractory period, a saturating signed potential and a saturating fire counter. One instance sits per neuron in the generated network, fed by synapse charge outputs. The network controller drives it with the same `clr`/`en` cycle strobes used across the network.

## Interface
Parameters:
- `NUM_INP`, 1: number of input charges.
- `CHARGE_WIDTH`, 8: signed width of each input charge.
- `POTENTIAL_WIDTH`, 12: signed width of the potential register.
- `THRESHOLD`, 0: threshold loaded at reset; signed, `POTENTIAL_WIDTH` bits.
- `POTENTIAL_MIN`, 0: lower clamp on stored potential; must be ≤ 0.
- `THRESHOLD_INCLUSIVE`, 1: 1 → fire on `sum >= thr`; 0 → fire on `sum > thr`.
- `LEAK_MODE`, 0: 0 = none; 1 = full leak (potential discarded each step); 2 = decay `p - (p >>> LEAK_SHIFT)`.
- `LEAK_SHIFT`, 1: decay shift, ≥ 1; used only in mode 2.
- `REFRACTORY`, 0: dead cycles after a fire; 0 disables the refractory period.
- `REGISTER_FIRE`, 0: 1 → `fire` is registered; 0 → `fire` is combinational.
- `COUNT_WIDTH`, 16: width of `fire_count`.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clr` in 1: synchronous clear of network state; threshold is retained.
- `en` in 1: step strobe; state advances only when high.
- `inp` in `NUM_INP`×`CHARGE_WIDTH`, signed: input charges for the current step.
- `thr_load` in 1: load `thr_value` into the threshold register.
- `thr_value` in `POTENTIAL_WIDTH`, signed: new threshold.
- `fire` out 1: spike for the current step (combinational, or registered when `REGISTER_FIRE=1`).
- `potential` out `POTENTIAL_WIDTH`, signed: stored potential, for observation.
- `refractory` out 1: high while the neuron is in the REFRACT state.
- `fire_count` out `COUNT_WIDTH`: number of fires since the last `rst`/`clr`; saturates.

## Operation
- State machine: NORMAL / REFRACT. Counter `rc` has width `$clog2(REFRACTORY+1)`; it is absent when `REFRACTORY=0`.
- Leak base `b`:
  - mode 0: `b = p`.
  - mode 1: `b = 0`.
  - mode 2: `b = p - (p >>> LEAK_SHIFT)`, using an arithmetic shift. For p = −1 this gives b = 0.
- Sum: `sum = b + Σ inp[i]`. `SUM_WIDTH = max(POTENTIAL_WIDTH, CHARGE_WIDTH) + $clog2(NUM_INP+1) + 1`. The sum never wraps.
- `do_fire = en && state==NORMAL && (sum >= thr, or sum > thr when THRESHOLD_INCLUSIVE=0)`.
- On an `en` cycle in NORMAL:
  - If `do_fire`: `p ← 0` and `fire_count` increments, saturating at all-ones. If `REFRACTORY > 0`, also `state ← REFRACT` and `rc ← REFRACTORY`.
  - Otherwise: `p ← clamp(sum, POTENTIAL_MIN, 2^(POTENTIAL_WIDTH-1)-1)`.
- On an `en` cycle in REFRACT:
  - Inputs are ignored and `p` is held at 0.
  - `rc` decrements; when `rc==1`, `state ← NORMAL` at the same edge.
  - Result: exactly `REFRACTORY` en-cycles are dead after the fire.
- When `en` is low, all of `p`, state, `rc`, `fire_count` and the registered `fire` hold.
- Threshold register `thr`:
  - Reset value is `THRESHOLD`.
  - `thr_load` writes it regardless of `en`, including during REFRACT.
  - A compare in the same cycle as `thr_load` uses the old value.
- Priority: `rst` > `clr` > `thr_load` / `en`.
  - `rst` resets everything, including `thr`.
  - `clr` resets everything except `thr`. A `thr_load` in the same cycle as `clr` is still performed.
- Reset values: `p=0`, state NORMAL, `rc=0`, `fire=0` (registered variant), `refractory=0`, `fire_count=0`.

## Timing
- `REGISTER_FIRE=0`: `fire` equals `do_fire` within the same cycle. There is a combinational path from `inp`, `en` and `thr` to `fire`.
- `REGISTER_FIRE=1`: `fire` is `do_fire` delayed by one edge.
  - It updates only on `en` cycles, so it holds between steps.
  - `clr` or `rst` forces it to 0.
- `potential`, `refractory` and `fire_count` are registered and reflect the step one edge later.
- Throughput: one step per `en` cycle; back-to-back `en` is supported.
- A `rst` or `clr` mid-refractory returns the neuron to NORMAL on the next edge.
- `fire_count` at all-ones stays at all-ones on further fires.

## Test plan
- Defaults with `THRESHOLD=5`, `NUM_INP=2`: inp=(2,2) for two `en` cycles → no fire then fire, `potential` 4 then 0, `fire_count`=1.
- `THRESHOLD_INCLUSIVE=0`, thr=5: sum exactly 5 → no fire, p=5. Next step inp=1 → fire.
- `LEAK_MODE=2`, `LEAK_SHIFT=1`, `POTENTIAL_MIN=-8`, thr=100: p=12, zero input → p sequence 6, 3, 2, 1, 1. Inputs of −20 → p clamps at −8.
- `REFRACTORY=3`, thr=1, inp=5 every cycle → fires on steps 0, 4, 8. `refractory` is high for steps 1–3. `en` low mid-refractory extends the wall-clock time but not the step count.
- `thr_load` of 10 in the same cycle as sum=6 with thr=5 → fire this cycle. The next sum=6 → no fire.
- `COUNT_WIDTH=2`, five fires → `fire_count` reads 1, 2, 3, 3, 3. Then `clr` → 0, with thr unchanged. `rst` → thr=`THRESHOLD`.
